// File: rtl/rv32i_types_pkg.sv
// Scalar RV32I shared types: machine word and load width/sign encoding (funct3).
package rv32i_types_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// RV32V memory sequencer types: element width, FSM states, EEW-to-LSC width mapping.
package rv32v_types_pkg;

    import rv32i_types_pkg::*;

    localparam int unsigned VLMAX_DEFAULT = 32;

    typedef enum logic [1:0] {
        EEW8  = 2'd0,
        EEW16 = 2'd1,
        EEW32 = 2'd2
    } vew_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } mseq_state_t;

    // Elements are zero-extended on load; the same code selects store width.
    function automatic load_t eew_to_load_t(input vew_t eew);
        case (eew)
            EEW8:    return LBU;
            EEW16:   return LHU;
            default: return LW;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_mseq_addr_gen.sv
// Element address / index generator for the vector memory sequencer.
// Build option: RV32V_STRIDED_EN selects a latched signed byte stride;
// otherwise the step is the element size (unit-stride).
module rv32v_mseq_addr_gen
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;
#(
    parameter int unsigned IDXW = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic            advance,
    input  word_t           base,
`ifdef RV32V_STRIDED_EN
    input  word_t           stride,
`else
    input  vew_t            eew,
`endif
    input  logic [IDXW:0]   vl,
    output word_t           addr_q,
    output logic [IDXW-1:0] idx,
    output logic            last
);

    word_t         step_q;
    logic [IDXW:0] vl_q;

    // Latch op parameters on accept; step one element per completed access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
            idx    <= '0;
            step_q <= '0;
            vl_q   <= '0;
        end else if (load) begin
            addr_q <= base;
            idx    <= '0;
            vl_q   <= vl;
`ifdef RV32V_STRIDED_EN
            step_q <= stride;
`else
            step_q <= 32'(1) << eew;
`endif
        end else if (advance) begin
            addr_q <= addr_q + step_q;
            idx    <= idx + IDXW'(1);
        end
    end

    // Current element is the final one of the op (vl_q >= 1 whenever this is consulted).
    assign last = ((IDXW+1)'(idx) == (vl_q - (IDXW+1)'(1)));

endmodule

// File: rtl/rv32v_mem_sequencer.sv
// RV32V memory sequencer: scalar passthrough to the LSC in IDLE, one LSC
// access per vector element otherwise. Build option: RV32V_STRIDED_EN.
module rv32v_mem_sequencer
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;
#(
    parameter int unsigned VLMAX = VLMAX_DEFAULT,
    parameter int unsigned IDXW  = $clog2(VLMAX)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            s_wen,
    input  logic            s_ren,
    input  word_t           s_addr,
    input  word_t           s_store_data,
    input  load_t           s_load_type,
    input  logic            s_ifence,
    output logic            s_stall,
    input  logic            v_start,
    output logic            v_ack,
    input  logic            v_is_store,
    input  word_t           v_base,
    input  word_t           v_stride,
    input  logic [IDXW:0]   v_vl,
    input  vew_t            v_eew,
    output logic            v_busy,
    output logic            v_done,
    output logic [IDXW-1:0] vrf_ridx,
    input  word_t           vrf_rdata,
    output logic            vrf_wen,
    output logic [IDXW-1:0] vrf_widx,
    output word_t           vrf_wdata,
    output logic            lsc_wen,
    output logic            lsc_ren,
    output word_t           lsc_addr,
    output word_t           lsc_store_data,
    output load_t           lsc_load_type,
    output logic            lsc_ifence,
    input  word_t           lsc_dload_ext,
    input  logic            lsc_busy,
    input  logic            lsc_fence_stall
);

    mseq_state_t     state;
    logic            is_store_q;
    vew_t            eew_q;
    word_t           addr_q;
    logic [IDXW-1:0] idx;
    logic            last;
    logic            xfer_done;

`ifndef RV32V_STRIDED_EN
    logic unused_stride;
    assign unused_stride = ^v_stride;
`endif

    // Scalar traffic has priority; a vector op is accepted only on a quiet scalar cycle.
    assign v_ack     = (state == IDLE) && v_start && !s_ren && !s_wen;
    assign xfer_done = (state == ISSUE) && !lsc_busy;

    rv32v_mseq_addr_gen #(
        .IDXW (IDXW)
    ) u_addr_gen (
        .CLK     (CLK),
        .RST     (RST),
        .load    (v_ack),
        .advance (xfer_done),
        .base    (v_base),
`ifdef RV32V_STRIDED_EN
        .stride  (v_stride),
`else
        .eew     (v_eew),
`endif
        .vl      (v_vl),
        .addr_q  (addr_q),
        .idx     (idx),
        .last    (last)
    );

    // Sequencer FSM and latched op attributes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            eew_q      <= EEW8;
        end else begin
            case (state)
                IDLE: begin
                    if (v_ack) begin
                        is_store_q <= v_is_store;
                        eew_q      <= v_eew;
                        state      <= (v_vl == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer_done && last) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // LSC request mux: scalar passthrough in IDLE, element access in ISSUE, quiet in DONE.
    always_comb begin
        lsc_wen        = 1'b0;
        lsc_ren        = 1'b0;
        lsc_addr       = '0;
        lsc_store_data = '0;
        lsc_load_type  = load_t'(3'b000);
        lsc_ifence     = 1'b0;
        s_stall        = 1'b1;
        v_busy         = 1'b1;
        case (state)
            IDLE: begin
                lsc_wen        = s_wen;
                lsc_ren        = s_ren;
                lsc_addr       = s_addr;
                lsc_store_data = s_store_data;
                lsc_load_type  = s_load_type;
                lsc_ifence     = s_ifence;
                s_stall        = lsc_fence_stall;
                v_busy         = 1'b0;
            end
            ISSUE: begin
                lsc_wen        = is_store_q;
                lsc_ren        = !is_store_q;
                lsc_addr       = addr_q;
                lsc_store_data = vrf_rdata;
                lsc_load_type  = eew_to_load_t(eew_q);
            end
            default: begin
            end
        endcase
    end

    // VRF side: store data read by index, load data written on completion.
    assign vrf_ridx  = idx;
    assign vrf_widx  = idx;
    assign vrf_wdata = lsc_dload_ext;
    assign vrf_wen   = xfer_done && !is_store_q;
    assign v_done    = (state == DONE);

endmodule

// File: tb/tb_rv32v_mem_sequencer.sv
// Directed self-checking bench for rv32v_mem_sequencer.
module tb_rv32v_mem_sequencer;
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;

    localparam int unsigned IDXW = 5;

    logic        CLK;
    logic        RST;
    logic        s_wen, s_ren, s_ifence, s_stall;
    word_t       s_addr, s_store_data;
    load_t       s_load_type;
    logic        v_start, v_ack, v_is_store, v_busy, v_done;
    word_t       v_base, v_stride;
    logic [IDXW:0] v_vl;
    vew_t        v_eew;
    logic [IDXW-1:0] vrf_ridx, vrf_widx;
    word_t       vrf_rdata, vrf_wdata;
    logic        vrf_wen;
    logic        lsc_wen, lsc_ren, lsc_ifence, lsc_busy, lsc_fence_stall;
    word_t       lsc_addr, lsc_store_data, lsc_dload_ext;
    load_t       lsc_load_type;

    int n_chk = 0;
    int n_bad = 0;

    rv32v_mem_sequencer dut (
        .CLK            (CLK),
        .RST            (RST),
        .s_wen          (s_wen),
        .s_ren          (s_ren),
        .s_addr         (s_addr),
        .s_store_data   (s_store_data),
        .s_load_type    (s_load_type),
        .s_ifence       (s_ifence),
        .s_stall        (s_stall),
        .v_start        (v_start),
        .v_ack          (v_ack),
        .v_is_store     (v_is_store),
        .v_base         (v_base),
        .v_stride       (v_stride),
        .v_vl           (v_vl),
        .v_eew          (v_eew),
        .v_busy         (v_busy),
        .v_done         (v_done),
        .vrf_ridx       (vrf_ridx),
        .vrf_rdata      (vrf_rdata),
        .vrf_wen        (vrf_wen),
        .vrf_widx       (vrf_widx),
        .vrf_wdata      (vrf_wdata),
        .lsc_wen        (lsc_wen),
        .lsc_ren        (lsc_ren),
        .lsc_addr       (lsc_addr),
        .lsc_store_data (lsc_store_data),
        .lsc_load_type  (lsc_load_type),
        .lsc_ifence     (lsc_ifence),
        .lsc_dload_ext  (lsc_dload_ext),
        .lsc_busy       (lsc_busy),
        .lsc_fence_stall(lsc_fence_stall)
    );

    // Simple VRF model: element i holds 0x5500_0000 | i.
    assign vrf_rdata = 32'h5500_0000 | 32'(vrf_ridx);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic st, input word_t base, input word_t stride,
                            input logic [IDXW:0] vl, input vew_t eew);
        v_start    = 1'b1;
        v_is_store = st;
        v_base     = base;
        v_stride   = stride;
        v_vl       = vl;
        v_eew      = eew;
    endtask

    initial begin
        RST = 1'b1;
        s_wen = 0; s_ren = 0; s_ifence = 0; s_addr = '0; s_store_data = '0; s_load_type = LB;
        v_start = 0; v_is_store = 0; v_base = '0; v_stride = '0; v_vl = '0; v_eew = EEW8;
        lsc_busy = 0; lsc_fence_stall = 0; lsc_dload_ext = '0;
        #12;
        chk("rst_busy", 32'(v_busy), 0);
        chk("rst_done", 32'(v_done), 0);
        chk("rst_ack", 32'(v_ack), 0);
        chk("rst_vrf_wen", 32'(vrf_wen), 0);
        chk("rst_lsc_ren", 32'(lsc_ren), 0);
        chk("rst_lsc_addr", lsc_addr, 0);
        tick();
        RST = 1'b0;
        tick();

        // 1. scalar passthrough
        s_ren = 1; s_addr = 32'h100; s_load_type = LW; #1;
        chk("t1_ren", 32'(lsc_ren), 1);
        chk("t1_addr", lsc_addr, 32'h100);
        chk("t1_type", 32'(lsc_load_type), 32'(LW));
        chk("t1_stall", 32'(s_stall), 0);
        lsc_fence_stall = 1; #1;
        chk("t1_fence_stall", 32'(s_stall), 1);
        lsc_fence_stall = 0; s_ren = 0;
        tick();

        // 2. unit load eew=32b, back-to-back
        start_op(1'b0, 32'h1000, 32'd4, 6'd4, EEW32); #1;
        chk("t2_ack", 32'(v_ack), 1);
        tick();
        v_start = 0;
        for (int i = 0; i < 4; i++) begin
            lsc_dload_ext = 32'hA000_0000 + 32'(i); #1;
            chk("t2_ren", 32'(lsc_ren), 1);
            chk("t2_addr", lsc_addr, 32'h1000 + 32'(4*i));
            chk("t2_type", 32'(lsc_load_type), 32'(LW));
            chk("t2_wen", 32'(vrf_wen), 1);
            chk("t2_widx", 32'(vrf_widx), 32'(i));
            chk("t2_wdata", vrf_wdata, 32'hA000_0000 + 32'(i));
            chk("t2_done_early", 32'(v_done), 0);
            tick();
        end
        chk("t2_done", 32'(v_done), 1);
        chk("t2_done_ren", 32'(lsc_ren), 0);
        chk("t2_done_busy", 32'(v_busy), 1);
        tick();
        chk("t2_idle_done", 32'(v_done), 0);
        chk("t2_idle_busy", 32'(v_busy), 0);

        // 3. store eew=8b, 2 busy cycles per element
        start_op(1'b1, 32'h2003, 32'd1, 6'd3, EEW8); #1;
        chk("t3_ack", 32'(v_ack), 1);
        tick();
        v_start = 0;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) begin
                lsc_busy = (c < 2); #1;
                chk("t3_wen", 32'(lsc_wen), 1);
                chk("t3_addr", lsc_addr, 32'h2003 + 32'(i));
                chk("t3_ridx", 32'(vrf_ridx), 32'(i));
                chk("t3_sdata", lsc_store_data, 32'h5500_0000 + 32'(i));
                chk("t3_type", 32'(lsc_load_type), 32'(LBU));
                chk("t3_vrf_wen", 32'(vrf_wen), 0);
                tick();
            end
        end
        lsc_busy = 0;
        chk("t3_done", 32'(v_done), 1);
        tick();

        // 4. vl=0
        start_op(1'b0, 32'h5000, 32'd4, 6'd0, EEW32); #1;
        chk("t4_ack", 32'(v_ack), 1);
        tick();
        v_start = 0; #1;
        chk("t4_done", 32'(v_done), 1);
        chk("t4_ren", 32'(lsc_ren), 0);
        chk("t4_wen", 32'(lsc_wen), 0);
        tick();
        chk("t4_idle", 32'(v_done), 0);

        // 5. contention
        s_wen = 1; s_addr = 32'h700;
        start_op(1'b0, 32'h3000, 32'd2, 6'd2, EEW16); #1;
        chk("t5_ack_blocked", 32'(v_ack), 0);
        chk("t5_scalar_wen", 32'(lsc_wen), 1);
        tick();
        s_wen = 0; #1;
        chk("t5_ack", 32'(v_ack), 1);
        tick();
        s_ren = 1; lsc_busy = 1; #1;
        chk("t5_ack_in_op", 32'(v_ack), 0);
        chk("t5_stall0", 32'(s_stall), 1);
        chk("t5_addr0", lsc_addr, 32'h3000);
        chk("t5_type", 32'(lsc_load_type), 32'(LHU));
        chk("t5_vwen_busy", 32'(vrf_wen), 0);
        tick();
        lsc_busy = 0; #1;
        chk("t5_addr0b", lsc_addr, 32'h3000);
        chk("t5_vwen0", 32'(vrf_wen), 1);
        tick();
        chk("t5_addr1", lsc_addr, 32'h3002);
        chk("t5_stall1", 32'(s_stall), 1);
        tick();
        chk("t5_done", 32'(v_done), 1);
        chk("t5_stall_done", 32'(s_stall), 1);
        tick();
        v_start = 0; #1;
        chk("t5_stall_after", 32'(s_stall), 0);
        chk("t5_scalar_ren", 32'(lsc_ren), 1);
        chk("t5_scalar_addr", lsc_addr, 32'h700);
        s_ren = 0;
        tick();

        // Address wrap past 0xFFFFFFFF
        start_op(1'b0, 32'hFFFF_FFFC, 32'd4, 6'd2, EEW32);
        tick();
        v_start = 0; #1;
        chk("wrap_a0", lsc_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_a1", lsc_addr, 32'h0000_0000);
        tick();
        chk("wrap_done", 32'(v_done), 1);
        tick();

        // Reset mid-op aborts without v_done
        start_op(1'b0, 32'h4000, 32'd4, 6'd4, EEW32);
        tick();
        v_start = 0;
        tick();
        tick();
        chk("abort_addr2", lsc_addr, 32'h4008);
        RST = 1; #1;
        chk("abort_vrf_wen", 32'(vrf_wen), 0);
        chk("abort_busy", 32'(v_busy), 0);
        chk("abort_ren", 32'(lsc_ren), 0);
        tick();
        RST = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort_no_done", 32'(v_done), 0);
            chk("abort_no_wen", 32'(vrf_wen), 0);
            tick();
        end

`ifdef RV32V_STRIDED_EN
        // 6. negative stride
        start_op(1'b0, 32'h10, 32'hFFFF_FFF8, 6'd4, EEW32);
        tick();
        v_start = 0; #1;
        chk("str_a0", lsc_addr, 32'h10);
        tick();
        chk("str_a1", lsc_addr, 32'h08);
        tick();
        chk("str_a2", lsc_addr, 32'h00);
        tick();
        chk("str_a3", lsc_addr, 32'hFFFF_FFF8);
        tick();
        chk("str_done", 32'(v_done), 1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
